// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic datapath (multiplier and round).
// Holds the sequencer state encoding and the operand/product width helpers.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int opw(input int intw, input int ratw);
    return intw + ratw;
  endfunction

  function automatic int prodw(input int intw, input int ratw);
    return intw + 2 * ratw;
  endfunction

endpackage

// File: rtl/fixed_mul_seq.sv
// Iterative unsigned shift-add multiplier: Q(INTW.RATW) x Q(INTW.RATW) -> Q(INTW.2*RATW).
// One multiplier bit is consumed per cycle, so every operation takes exactly W cycles.
module fixed_mul_seq
  import fixed_pkg::*;
#(
  parameter int INTW = 10,
  parameter int RATW = 2,
  parameter bit SAT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INTW+RATW-1:0]   in_a,
  input  logic [INTW+RATW-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INTW+2*RATW-1:0] out_prod,
  output logic                   out_ovf
);

  localparam int W  = opw(INTW, RATW);
  localparam int PW = prodw(INTW, RATW);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          state;
  state_t          state_next;
  logic [2*W-1:0]  a_sh;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_next;
  logic [W-1:0]    b_sh;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last_step;
  logic            ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accumulator spans the full 2W-bit product, so overflow is judged on the final sum.
  assign acc_next = acc + (b_sh[0] ? a_sh : '0);
  assign ovf_next = |acc_next[2*W-1:PW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_prod <= '0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      a_sh <= {{W{1'b0}}, in_a};
      b_sh <= in_b;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (last_step) begin
        out_ovf  <= ovf_next;
        out_prod <= (SAT && ovf_next) ? '1 : acc_next[PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Self-checking bench for fixed_mul_seq: a saturating and a wrapping instance run in lockstep
// and are compared against plain integer products of the operands.
module tb_fixed_mul_seq;

  localparam int INTW = 10;
  localparam int RATW = 2;
  localparam int W    = INTW + RATW;
  localparam int PW   = INTW + 2 * RATW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prod;
  logic          out_ovf;
  logic          in_ready_w;
  logic          out_valid_w;
  logic [PW-1:0] out_prod_w;
  logic          out_ovf_w;

  int checks;
  int failures;

  fixed_mul_seq #(.INTW(INTW), .RATW(RATW), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_ovf(out_ovf)
  );

  fixed_mul_seq #(.INTW(INTW), .RATW(RATW), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_prod(out_prod_w), .out_ovf(out_ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact integer product, then the 14-bit output view of it.
  function automatic longint ref_full(input int a, input int b);
    return longint'(a) * longint'(b);
  endfunction

  function automatic logic ref_ovf(input int a, input int b);
    return ref_full(a, b) >= (longint'(1) << PW);
  endfunction

  function automatic logic [PW-1:0] ref_sat(input int a, input int b);
    if (ref_ovf(a, b)) return {PW{1'b1}};
    return PW'(ref_full(a, b) % (longint'(1) << PW));
  endfunction

  function automatic logic [PW-1:0] ref_wrap(input int a, input int b);
    return PW'(ref_full(a, b) % (longint'(1) << PW));
  endfunction

  // Presents one operand pair once idle and returns the edge count from accept to out_valid.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid got=%0b want=0", out_valid);
    end
    if (out_prod !== '0) begin
      failures++;
      $display("[TB] FAIL reset_prod got=%0d want=0", out_prod);
    end
    if (out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ovf got=%0b want=0", out_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%0b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    issue(12'd6, 12'd9, lat);
    checks += 4;
    if (lat !== 12) begin
      failures++;
      $display("[TB] FAIL basic_latency got=%0d want=12", lat);
    end
    if (out_prod !== 14'd54) begin
      failures++;
      $display("[TB] FAIL basic_prod got=%0d want=54", out_prod);
    end
    if (out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_ovf got=%0b want=0", out_ovf);
    end
    if (out_prod_w !== 14'd54) begin
      failures++;
      $display("[TB] FAIL basic_prod_wrap got=%0d want=54", out_prod_w);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_valid_pulse got=%0b want=0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int lat;
    out_ready = 1'b1;
    issue(12'd4095, 12'd4095, lat);
    checks += 5;
    if (lat !== 12) begin
      failures++;
      $display("[TB] FAIL ovf_latency got=%0d want=12", lat);
    end
    if (out_prod !== 14'd16383 || out_ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sat got=%0d/%0b want=16383/1", out_prod, out_ovf);
    end
    if (out_prod_w !== 14'd8193) begin
      failures++;
      $display("[TB] FAIL ovf_wrap_prod got=%0d want=8193", out_prod_w);
    end
    if (out_ovf_w !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_wrap_flag got=%0b want=1", out_ovf_w);
    end
    if (out_prod !== ref_sat(4095, 4095)) begin
      failures++;
      $display("[TB] FAIL ovf_model got=%0d want=%0d", out_prod, ref_sat(4095, 4095));
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    logic [W-1:0] za [2];
    logic [W-1:0] zb [2];
    za[0] = 12'd0;    zb[0] = 12'd4095;
    za[1] = 12'd4095; zb[1] = 12'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(za[k], zb[k], lat);
      checks += 2;
      if (lat !== 12) begin
        failures++;
        $display("[TB] FAIL zero_latency case=%0d got=%0d want=12", k, lat);
      end
      if (out_prod !== '0 || out_ovf !== 1'b0) begin
        failures++;
        $display("[TB] FAIL zero_prod case=%0d got=%0d/%0b want=0/0", k, out_prod, out_ovf);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom_range(1, 4095));
    b = W'($urandom_range(1, 4095));
    out_ready = 1'b0;
    issue(a, b, lat);
    checks++;
    if (lat !== 12) begin
      failures++;
      $display("[TB] FAIL bp_latency got=%0d want=12", lat);
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      checks += 2;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_handshake cyc=%0d valid=%0b ready=%0b want=1/0", s, out_valid, in_ready);
      end
      if (out_prod !== ref_sat(a, b) || out_ovf !== ref_ovf(a, b)) begin
        failures++;
        $display("[TB] FAIL bp_stable cyc=%0d got=%0d/%0b want=%0d/%0b", s, out_prod, out_ovf, ref_sat(a, b), ref_ovf(a, b));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_transfer valid=%0b ready=%0b want=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    in_a     = 12'd4095;
    in_b     = 12'd4095;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_prod !== '0) begin
      failures++;
      $display("[TB] FAIL midrst_clear valid=%0b prod=%0d want=0/0", out_valid, out_prod);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_ready ready=%0b valid=%0b want=1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    issue(12'd8, 12'd8, lat);
    checks += 2;
    if (lat !== 12) begin
      failures++;
      $display("[TB] FAIL midrst_latency got=%0d want=12", lat);
    end
    if (out_prod !== 14'd64 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_prod got=%0d/%0b want=64/0", out_prod, out_ovf);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    int stall;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = 12'd4095;
      if ($urandom_range(0, 7) == 0) b = W'($urandom_range(0, 3));
      stall = $urandom_range(0, 3);
      out_ready = 1'b0;
      issue(a, b, lat);
      checks += 4;
      if (lat !== 12) begin
        failures++;
        $display("[TB] FAIL rand_latency n=%0d got=%0d want=12", n, lat);
      end
      if (out_prod !== ref_sat(a, b) || out_ovf !== ref_ovf(a, b)) begin
        failures++;
        $display("[TB] FAIL rand_sat n=%0d a=%0d b=%0d got=%0d/%0b want=%0d/%0b", n, a, b, out_prod, out_ovf, ref_sat(a, b), ref_ovf(a, b));
      end
      if (out_prod_w !== ref_wrap(a, b) || out_ovf_w !== ref_ovf(a, b)) begin
        failures++;
        $display("[TB] FAIL rand_wrap n=%0d a=%0d b=%0d got=%0d/%0b want=%0d/%0b", n, a, b, out_prod_w, out_ovf_w, ref_wrap(a, b), ref_ovf(a, b));
      end
      repeat (stall) @(negedge clk);
      if (out_valid !== 1'b1 || out_valid_w !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rand_hold n=%0d valid=%0b/%0b want=1/1", n, out_valid, out_valid_w);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
